decode_bundle_buffer: RTL and testbench

Multi-lane registered decode stage for the out-of-order RV32I pipeline. Sits between the fetch-bundle queue and rename. Each cycle it accepts up to `LANES` instructions and decodes each lane's opcode into a control bundle. It kills lanes that follow a taken-by-definition jump or an illegal opcode, and holds results in a two-entry skid buffer behind a valid/ready handshake.

---
 rtl/decode_bundle_buffer.sv | 190 +++++++++++++++++++
 tb/tb_decode_bundle_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_bundle_buffer.sv
// Multi-lane RV32I decode stage: per-lane opcode decode, kill after jump/illegal,
// and a two-entry head/skid buffer behind a valid/ready handshake.
module decode_bundle_buffer #(
    parameter int LANES  = 2,
    parameter int CTRL_W = 13
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_lane_valid,
    input  logic [LANES*32-1:0]     in_insn,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_lane_valid,
    output logic [LANES*32-1:0]     out_insn,
    output logic [LANES*CTRL_W-1:0] out_ctrl
);

    // Encoding is {skid_valid, head_valid} so both flags are plain register bits.
    localparam logic [1:0] S_EMPTY = 2'b00;
    localparam logic [1:0] S_ONE   = 2'b01;
    localparam logic [1:0] S_TWO   = 2'b11;

    function automatic logic [CTRL_W-1:0] decode_ctrl(input logic [6:0] opcode);
        logic       illegal, branch, mem_read, mem_write;
        logic       alu_src_imm, reg_write, alu_src_pc, jump;
        logic [1:0] write_data, alu_op;
        illegal     = 1'b0;
        branch      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        alu_src_imm = 1'b0;
        reg_write   = 1'b0;
        alu_src_pc  = 1'b0;
        jump        = 1'b0;
        write_data  = 2'd0;
        alu_op      = 2'd2;
        case (opcode)
            7'b0110011: reg_write = 1'b1;
            7'b0010011: begin
                alu_src_imm = 1'b1;
                reg_write   = 1'b1;
            end
            7'b0000011: begin
                write_data  = 2'd1;
                alu_op      = 2'd0;
                alu_src_imm = 1'b1;
                reg_write   = 1'b1;
                mem_read    = 1'b1;
            end
            7'b1100111: begin
                write_data  = 2'd2;
                alu_op      = 2'd0;
                alu_src_imm = 1'b1;
                reg_write   = 1'b1;
                jump        = 1'b1;
            end
            7'b0100011: begin
                alu_op      = 2'd0;
                alu_src_imm = 1'b1;
                mem_write   = 1'b1;
            end
            7'b1100011: begin
                branch = 1'b1;
                alu_op = 2'd1;
            end
            7'b1101111: begin
                write_data  = 2'd2;
                alu_op      = 2'd0;
                alu_src_imm = 1'b1;
                reg_write   = 1'b1;
                alu_src_pc  = 1'b1;
                jump        = 1'b1;
            end
            7'b0110111: begin
                reg_write   = 1'b1;
                alu_src_imm = 1'b1;
            end
            7'b0010111: begin
                reg_write   = 1'b1;
                alu_src_imm = 1'b1;
                alu_src_pc  = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        return {illegal, branch, mem_read, write_data, alu_op, mem_write,
                alu_src_imm, reg_write, alu_src_pc, jump, 1'b0};
    endfunction

    logic [1:0]              state, state_next;
    logic [LANES-1:0]        dec_lv_p0;
    logic [LANES*CTRL_W-1:0] dec_ctrl_p0;
    logic                    kill_p0;
    logic                    enq, deq;
    logic                    load_head, load_skid, promote;

    logic [LANES-1:0]        head_lv_p1, skid_lv_p1;
    logic [LANES*32-1:0]     head_insn_p1, skid_insn_p1;
    logic [LANES*CTRL_W-1:0] head_ctrl_p1, skid_ctrl_p1;

    // Decode stage: lanes past the first valid jump/illegal lane are dropped.
    always_comb begin
        dec_lv_p0   = '0;
        dec_ctrl_p0 = '0;
        kill_p0     = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (in_lane_valid[i] && !kill_p0) begin
                dec_lv_p0[i] = 1'b1;
                dec_ctrl_p0[i*CTRL_W +: CTRL_W] = decode_ctrl(in_insn[i*32 +: 7]);
                if (dec_ctrl_p0[i*CTRL_W + CTRL_W - 1] || dec_ctrl_p0[i*CTRL_W + 1])
                    kill_p0 = 1'b1;
            end
        end
    end

    assign in_ready  = ~state[1];
    assign out_valid = state[0];
    // Empty bundles complete the handshake but never occupy an entry.
    assign enq = in_valid && in_ready && !flush && (|in_lane_valid);
    assign deq = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S_EMPTY;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = S_EMPTY;
        end else begin
            case (state)
                S_EMPTY: if (enq) state_next = S_ONE;
                S_ONE: begin
                    if (enq && !deq)
                        state_next = S_TWO;
                    else if (deq && !enq)
                        state_next = S_EMPTY;
                end
                S_TWO:   if (deq) state_next = S_ONE;
                default: state_next = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        load_head = 1'b0;
        load_skid = 1'b0;
        promote   = 1'b0;
        if (!flush) begin
            load_head = enq && ((state == S_EMPTY) || ((state == S_ONE) && deq));
            load_skid = enq && (state == S_ONE) && !deq;
            promote   = deq && (state == S_TWO);
        end
    end

    // Buffer stage: head drives the outputs directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_lv_p1   <= '0;
            head_insn_p1 <= '0;
            head_ctrl_p1 <= '0;
        end else if (load_head) begin
            head_lv_p1   <= dec_lv_p0;
            head_insn_p1 <= in_insn;
            head_ctrl_p1 <= dec_ctrl_p0;
        end else if (promote) begin
            head_lv_p1   <= skid_lv_p1;
            head_insn_p1 <= skid_insn_p1;
            head_ctrl_p1 <= skid_ctrl_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_lv_p1   <= dec_lv_p0;
            skid_insn_p1 <= in_insn;
            skid_ctrl_p1 <= dec_ctrl_p0;
        end
    end

    assign out_lane_valid = head_lv_p1;
    assign out_insn       = head_insn_p1;
    assign out_ctrl       = head_ctrl_p1;

endmodule

// File: tb/tb_decode_bundle_buffer.sv
// Bench for decode_bundle_buffer: decode table vectors, handshake corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_decode_bundle_buffer;

    localparam int L  = 2;
    localparam int CW = 13;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [L-1:0]    in_lane_valid;
    logic [L*32-1:0] in_insn;
    logic            out_valid;
    logic            out_ready;
    logic [L-1:0]    out_lane_valid;
    logic [L*32-1:0] out_insn;
    logic [L*CW-1:0] out_ctrl;

    decode_bundle_buffer #(.LANES(L), .CTRL_W(CW)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_lane_valid  (in_lane_valid),
        .in_insn        (in_insn),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_lane_valid (out_lane_valid),
        .out_insn       (out_insn),
        .out_ctrl       (out_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [L-1:0]    lv;
        logic [L*32-1:0] insn;
        logic [L*CW-1:0] ctrl;
    } bundle_t;

    typedef struct {
        logic [1:0]  lv;
        logic [31:0] i0;
        logic [31:0] i1;
        logic [1:0]  elv;
        logic [12:0] c0;
        logic [12:0] c1;
    } vec_t;

    bundle_t q[$];
    int      vectors;
    int      miscompares;

    // Reference decode: named fields per opcode, packed MSB-first.
    function automatic logic [12:0] ref_ctrl(input logic [31:0] insn);
        bit         ill = 0, br = 0, mr = 0, mw = 0, imm = 0, rw = 0, pc = 0, j = 0;
        logic [1:0] wd = 2'd0;
        logic [1:0] aop = 2'd2;
        case (insn[6:0])
            7'h33: rw = 1;
            7'h13: begin imm = 1; rw = 1; end
            7'h03: begin wd = 1; aop = 0; imm = 1; rw = 1; mr = 1; end
            7'h67: begin wd = 2; aop = 0; imm = 1; rw = 1; j = 1; end
            7'h23: begin aop = 0; imm = 1; mw = 1; end
            7'h63: begin br = 1; aop = 1; end
            7'h6F: begin wd = 2; aop = 0; imm = 1; rw = 1; pc = 1; j = 1; end
            7'h37: begin rw = 1; imm = 1; end
            7'h17: begin rw = 1; imm = 1; pc = 1; end
            default: ill = 1;
        endcase
        return {ill, br, mr, wd, aop, mw, imm, rw, pc, j, 1'b0};
    endfunction

    function automatic bundle_t ref_bundle(input logic [L-1:0] lv, input logic [L*32-1:0] insn);
        bundle_t     b;
        bit          dead = 0;
        logic [12:0] c;
        b.lv   = '0;
        b.ctrl = '0;
        b.insn = insn;
        for (int i = 0; i < L; i++) begin
            if (lv[i] && !dead) begin
                c = ref_ctrl(insn[i*32 +: 32]);
                b.lv[i] = 1'b1;
                b.ctrl[i*CW +: CW] = c;
                if (c[12] || c[1]) dead = 1;
            end
        end
        return b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
        check("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
        if (q.size() > 0) begin
            check("out_lane_valid", {62'd0, out_lane_valid}, {62'd0, q[0].lv});
            check("out_insn", out_insn, q[0].insn);
            check("out_ctrl", {38'd0, out_ctrl}, {38'd0, q[0].ctrl});
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic cycle();
        bit deq, acc;
        @(posedge clk);
        deq = (q.size() > 0) && out_ready;
        acc = in_valid && (q.size() < 2) && !flush;
        if (flush) begin
            q.delete();
        end else begin
            if (deq) void'(q.pop_front());
            if (acc && in_lane_valid != '0) q.push_back(ref_bundle(in_lane_valid, in_insn));
        end
        #1;
        check_outputs();
    endtask

    task automatic offer(input logic [1:0] lv, input logic [31:0] i0, input logic [31:0] i1);
        in_valid      = 1'b1;
        in_lane_valid = lv;
        in_insn       = {i1, i0};
    endtask

    vec_t        tbl[10];
    logic [6:0]  ops[10];
    logic [31:0] r0, r1;

    initial begin
        vectors     = 0;
        miscompares = 0;
        tbl[0] = '{2'b11, 32'h0000_0033, 32'h0000_2003, 2'b11, 13'h0088, 13'h0518};
        tbl[1] = '{2'b11, 32'h0000_006F, 32'h0000_0033, 2'b01, 13'h021E, 13'h0000};
        tbl[2] = '{2'b11, 32'h0000_007F, 32'h0000_0033, 2'b01, 13'h1080, 13'h0000};
        tbl[3] = '{2'b11, 32'h0000_0063, 32'h0000_0013, 2'b11, 13'h0840, 13'h0098};
        tbl[4] = '{2'b10, 32'h0000_006F, 32'h0000_0067, 2'b10, 13'h0000, 13'h021A};
        tbl[5] = '{2'b10, 32'h0000_007F, 32'h0000_0033, 2'b10, 13'h0000, 13'h0088};
        tbl[6] = '{2'b01, 32'h0000_0023, 32'h0000_006F, 2'b01, 13'h0030, 13'h0000};
        tbl[7] = '{2'b11, 32'h1234_5037, 32'h0000_1017, 2'b11, 13'h0098, 13'h009C};
        tbl[8] = '{2'b11, 32'h0000_0067, 32'h0000_007F, 2'b01, 13'h021A, 13'h0000};
        tbl[9] = '{2'b11, 32'h0000_0033, 32'h0000_0000, 2'b11, 13'h0088, 13'h1080};
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h7F};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_lane_valid = '0; in_insn = '0;
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_lane_valid", {62'd0, out_lane_valid}, 64'd0);
        check("rst_insn", out_insn, 64'd0);
        check("rst_ctrl", {38'd0, out_ctrl}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors, streamed back to back with out_ready high.
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            offer(tbl[k].lv, tbl[k].i0, tbl[k].i1);
            cycle();
            check("tbl_valid", {63'd0, out_valid}, 64'd1);
            check("tbl_lane_valid", {62'd0, out_lane_valid}, {62'd0, tbl[k].elv});
            check("tbl_ctrl0", {51'd0, out_ctrl[12:0]}, {51'd0, tbl[k].c0});
            check("tbl_ctrl1", {51'd0, out_ctrl[25:13]}, {51'd0, tbl[k].c1});
            check("tbl_insn", out_insn, {tbl[k].i1, tbl[k].i0});
        end
        in_valid = 1'b0;
        cycle();

        // Backpressure: A and B fill the buffer, C waits upstream.
        out_ready = 1'b0;
        offer(2'b11, 32'h0000_0033, 32'h0000_0013); cycle();
        offer(2'b11, 32'h0000_0003, 32'h0000_0023); cycle();
        check("bp_in_ready_full", {63'd0, in_ready}, 64'd0);
        offer(2'b01, 32'h0000_0063, 32'h0000_0037); cycle();
        check("bp_head_is_a", {38'd0, out_ctrl}, {38'd0, 13'h0098, 13'h0088});
        out_ready = 1'b1;
        cycle();
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();

        // Flush with both entries occupied; the flush-cycle bundle is dropped.
        out_ready = 1'b0;
        offer(2'b11, 32'h0000_0017, 32'h0000_0037); cycle();
        offer(2'b11, 32'h0000_0013, 32'h0000_0033); cycle();
        check("fl_full", {63'd0, in_ready}, 64'd0);
        flush = 1'b1;
        offer(2'b11, 32'h0000_0003, 32'h0000_0003); cycle();
        check("fl_out_valid", {63'd0, out_valid}, 64'd0);
        check("fl_in_ready", {63'd0, in_ready}, 64'd1);
        flush = 1'b0;
        offer(2'b01, 32'h0000_0023, 32'h0000_0000); cycle();
        check("fl_next_ctrl", {38'd0, out_ctrl}, {38'd0, 13'h0000, 13'h0030});
        out_ready = 1'b1;
        in_valid  = 1'b0;
        cycle();

        // Asynchronous reset between edges while a bundle is held.
        out_ready = 1'b0;
        offer(2'b11, 32'h0000_0033, 32'h0000_0033); cycle();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        q.delete();
        check("ar_out_valid", {63'd0, out_valid}, 64'd0);
        check("ar_ctrl", {38'd0, out_ctrl}, 64'd0);
        check("ar_in_ready", {63'd0, in_ready}, 64'd1);
        #1;
        rst = 1'b0;
        offer(2'b00, 32'h0000_0033, 32'h0000_0033);
        cycle();
        check("ar_empty_in_ready", {63'd0, in_ready}, 64'd1);
        check("ar_empty_out_valid", {63'd0, out_valid}, 64'd0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            r0 = $urandom();
            r1 = $urandom();
            if ($urandom_range(0, 9) != 0) r0[6:0] = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) != 0) r1[6:0] = ops[$urandom_range(0, 9)];
            in_valid      = ($urandom_range(0, 3) != 0);
            in_lane_valid = 2'($urandom_range(0, 3));
            in_insn       = {r1, r0};
            out_ready     = ($urandom_range(0, 2) != 0);
            flush         = ($urandom_range(0, 24) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
